// File: rtl/arb_pkg.sv
// Shared types for the round-robin / fixed-priority arbiter.
package arb_pkg;
  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;
  typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational rotated find-first: picks the first set request at or after
// the start index (ptr in round-robin, 0 in fixed mode), wrapping mod N.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_mode,
  output logic          o_found,
  output logic [IW-1:0] o_idx,
  output logic [N-1:0]  o_onehot
);

  logic [IW-1:0]  w_start;
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;

  always_comb begin
    w_start  = (i_mode == ARB_RR) ? i_ptr : '0;
    w_dbl    = {i_req, i_req} >> w_start;
    w_rot    = w_dbl[N-1:0];
    o_found  = 1'b0;
    w_off    = '0;
    for (int i = 0; i < N; i++) begin
      if (w_rot[i]) begin
        o_found = 1'b1;
        w_off   = IW'(i);
        break;
      end
    end
    // Un-rotate; N need not be a power of two so reduce explicitly.
    w_sum = {1'b0, w_start} + {1'b0, w_off};
    if (w_sum >= (IW+1)'(N))
      w_sum = w_sum - (IW+1)'(N);
    o_idx    = w_sum[IW-1:0];
    o_onehot = o_found ? (N'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// N-channel arbiter with registered grant ownership, fixed or round-robin
// priority and an optional hold-time limit that forces rotation.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);

  localparam int IW = $clog2(N);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

  arb_state_t    r_state, w_state_nx;
  logic [N-1:0]  r_grant, w_grant_nx;
  logic [IW-1:0] r_idx,   w_idx_nx;
  logic [IW-1:0] r_ptr,   w_ptr_nx;
  logic [HW-1:0] r_hold,  w_hold_nx;

  logic [N-1:0]  w_masked;
  logic          w_found;
  logic [IW-1:0] w_win_idx;
  logic [N-1:0]  w_win_oh;
  logic [IW-1:0] w_win_ptr;
  logic          w_owner_req;
  logic          w_take;

  // r_grant is zero when idle, so this mask also serves the IDLE arbitration.
  assign w_masked    = req & ~r_grant;
  assign w_owner_req = |(req & r_grant);
  assign w_win_ptr   = (w_win_idx == IDX_LAST) ? '0 : w_win_idx + IW'(1);

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .i_req    (w_masked),
    .i_ptr    (r_ptr),
    .i_mode   (mode),
    .o_found  (w_found),
    .o_idx    (w_win_idx),
    .o_onehot (w_win_oh)
  );

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_idx_nx   = r_idx;
    w_ptr_nx   = r_ptr;
    w_hold_nx  = r_hold;
    w_take     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_take = 1'b1;
      end
      ST_BUSY: begin
        if (!w_owner_req) begin
          if (w_found) begin
            w_take = 1'b1;
          end else begin
            w_state_nx = ST_IDLE;
            w_grant_nx = '0;
            w_idx_nx   = '0;
            w_hold_nx  = '0;
          end
        end else if (MAX_HOLD != 0 && r_hold == HOLD_LAST && w_found) begin
          w_take = 1'b1;
        end else if (MAX_HOLD != 0 && r_hold != HOLD_LAST) begin
          w_hold_nx = r_hold + HW'(1);
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    if (w_take) begin
      w_state_nx = ST_BUSY;
      w_grant_nx = w_win_oh;
      w_idx_nx   = w_win_idx;
      w_ptr_nx   = w_win_ptr;
      w_hold_nx  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_idx   <= w_idx_nx;
      r_ptr   <= w_ptr_nx;
      r_hold  <= w_hold_nx;
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = r_idx;
  assign grant_valid = |r_grant;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Bench for rr_priority_arbiter: directed literal checks plus randomized
// traffic against a behavioural ownership model, on N=4/MAX_HOLD=4 and N=5/MAX_HOLD=0.
module tb_rr_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [3:0] req4;
  logic [4:0] req5;
  logic [3:0] grant4;
  logic [1:0] idx4;
  logic       vld4;
  logic [4:0] grant5;
  logic [2:0] idx5;
  logic       vld5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rr_priority_arbiter #(.N(4), .MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .req(req4),
    .grant(grant4), .grant_idx(idx4), .grant_valid(vld4)
  );

  rr_priority_arbiter #(.N(5), .MAX_HOLD(0)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .req(req5),
    .grant(grant5), .grant_idx(idx5), .grant_valid(vld5)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner = -1 means nobody holds the grant.
  task automatic mstep(input int n, input int mh, input logic md, input logic [7:0] rq,
                       input int own, input int ptr, input int hold,
                       output int nown, output int nptr, output int nhold);
    logic [7:0] avail;
    int win, start;
    avail = rq;
    if (own >= 0) avail[own] = 1'b0;
    win = -1;
    start = md ? ptr : 0;
    for (int off = 0; off < n; off++) begin
      int c;
      c = (start + off) % n;
      if (avail[c]) begin win = c; break; end
    end
    nown = own; nptr = ptr; nhold = hold;
    if (own < 0 || !rq[own] || (mh != 0 && hold == mh - 1)) begin
      if (win >= 0) begin
        nown = win; nptr = (win + 1) % n; nhold = 0;
      end else if (own < 0 || !rq[own]) begin
        nown = -1; nhold = 0;
      end
    end else if (mh != 0) begin
      nhold = hold + 1;
    end
  endtask

  int m4_own, m4_ptr, m4_hold, m5_own, m5_ptr, m5_hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4_own <= -1; m4_ptr <= 0; m4_hold <= 0;
      m5_own <= -1; m5_ptr <= 0; m5_hold <= 0;
    end else begin
      int o, p, h;
      mstep(4, 4, mode, {4'b0, req4}, m4_own, m4_ptr, m4_hold, o, p, h);
      m4_own <= o; m4_ptr <= p; m4_hold <= h;
      mstep(5, 0, mode, {3'b0, req5}, m5_own, m5_ptr, m5_hold, o, p, h);
      m5_own <= o; m5_ptr <= p; m5_hold <= h;
    end
  end

  // Compare process: outputs are registered, so mid-cycle they reflect the model state.
  always @(negedge clk) begin
    chk("model grant4", {28'b0, grant4}, (m4_own >= 0) ? (32'd1 << m4_own) : 32'd0);
    chk("model idx4",   {30'b0, idx4},   (m4_own >= 0) ? m4_own : 0);
    chk("model vld4",   {31'b0, vld4},   {31'b0, m4_own >= 0});
    chk("model grant5", {27'b0, grant5}, (m5_own >= 0) ? (32'd1 << m5_own) : 32'd0);
    chk("model idx5",   {29'b0, idx5},   (m5_own >= 0) ? m5_own : 0);
    chk("model vld5",   {31'b0, vld5},   {31'b0, m5_own >= 0});
  end

  initial begin
    rst_n = 1'b0; mode = 1'b1; req4 = 4'b1111; req5 = '0;
    repeat (2) @(negedge clk);
    chk("reset grant", {28'b0, grant4}, 0);
    chk("reset valid", {31'b0, vld4}, 0);
    chk("reset idx",   {30'b0, idx4}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first grant", {28'b0, grant4}, 32'h1);
    chk("first idx",   {30'b0, idx4}, 0);

    // Round-robin with hold limit 4: each owner keeps exactly 4 cycles.
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("rr idx",   {30'b0, idx4}, (k / 4) % 4);
      chk("rr valid", {31'b0, vld4}, 1);
    end

    // Fixed priority, no preemption of owner 3 by channel 0.
    mode = 1'b0; req4 = 4'b1000;
    @(negedge clk);
    chk("fixed owner3", {30'b0, idx4}, 3);
    req4 = 4'b1001;
    repeat (2) begin
      @(negedge clk);
      chk("no preempt", {30'b0, idx4}, 3);
    end
    req4 = 4'b0001;
    @(negedge clk);
    chk("handover idx", {30'b0, idx4}, 0);
    chk("handover grant", {28'b0, grant4}, 32'h1);

    // Release with no other requesters; ptr then sits at 3.
    mode = 1'b1; req4 = 4'b0000;
    @(negedge clk);
    chk("idle valid", {31'b0, vld4}, 0);
    req4 = 4'b0100;
    repeat (3) begin
      @(negedge clk);
      chk("pulse grant", {28'b0, grant4}, 32'h4);
    end
    req4 = 4'b0000;
    @(negedge clk);
    chk("release valid", {31'b0, vld4}, 0);
    chk("release idx",   {30'b0, idx4}, 0);
    req4 = 4'b1111;
    @(negedge clk);
    chk("ptr after 2", {30'b0, idx4}, 3);

    // Asynchronous reset while channel 2 owns.
    req4 = 4'b0000;
    @(negedge clk);
    req4 = 4'b0100;
    @(negedge clk);
    chk("own2", {30'b0, idx4}, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async grant", {28'b0, grant4}, 0);
    chk("async valid", {31'b0, vld4}, 0);
    chk("async idx",   {30'b0, idx4}, 0);
    req4 = 4'b1111; mode = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post reset idx", {30'b0, idx4}, 0);

    // N=5 wrap.
    req5 = 5'b10000;
    @(negedge clk);
    chk("n5 idx4", {29'b0, idx5}, 4);
    req5 = 5'b00000;
    @(negedge clk);
    chk("n5 idle", {31'b0, vld5}, 0);
    req5 = 5'b10001;
    @(negedge clk);
    chk("n5 wrap idx", {29'b0, idx5}, 0);

    // Randomized traffic: mostly-held requests with occasional flips.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) mode = 1'($urandom_range(0, 1));
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) req4[b] = ~req4[b];
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 7) == 0) req5[b] = ~req5[b];
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rand async grant4", {28'b0, grant4}, 0);
        chk("rand async grant5", {27'b0, grant5}, 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
